// File: rtl/xy_route_pipe.sv
// xy_route_pipe: registered XY route stage that holds the header's route for body/tail flits.
// Define XY_ROUTE_ERR_CNT_EN to add the saturating err_cnt output.
module xy_route_pipe #(
   parameter int unsigned X_NODE_NUM = 4,
   parameter int unsigned Y_NODE_NUM = 4,
   parameter int unsigned X_CUR      = 1,
   parameter int unsigned Y_CUR      = 1,
   parameter int unsigned FLIT_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [FLIT_W-1:0] in_flit,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [FLIT_W-1:0] out_flit,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        out_port_num,
   output logic [4:0]        out_port_oh,
`ifdef XY_ROUTE_ERR_CNT_EN
   output logic              err,
   output logic [7:0]        err_cnt
`else
   output logic              err
`endif
);
   localparam int unsigned XW = (X_NODE_NUM > 1) ? $clog2(X_NODE_NUM) : 1;
   localparam int unsigned YW = (Y_NODE_NUM > 1) ? $clog2(Y_NODE_NUM) : 1;

   localparam logic [1:0] FtBody    = 2'b00;
   localparam logic [1:0] FtTail    = 2'b01;
   localparam logic [1:0] FtHdr     = 2'b10;
   localparam logic [1:0] FtHdrTail = 2'b11;

   localparam logic [2:0] PortNone = 3'd0;
   localparam logic [2:0] PortL    = 3'd1;
   localparam logic [2:0] PortE    = 3'd2;
   localparam logic [2:0] PortN    = 3'd3;
   localparam logic [2:0] PortW    = 3'd4;
   localparam logic [2:0] PortS    = 3'd5;

   typedef enum logic [1:0] {StIdle, StPkt, StDrop} state_e;

   state_e            state_q, state_d;
   logic [2:0]        route_q, route_d;
   logic [FLIT_W-1:0] flit_q, flit_d;
   logic              valid_q, valid_d;
   logic [2:0]        port_q, port_d;
   logic              err_q, err_d;

   logic [1:0]  ftype;
   logic [31:0] xd, yd;
   logic        addr_ok;
   logic [2:0]  calc_port;
   logic        accept;
   logic        emit;
   logic [2:0]  emit_port;

   assign ftype   = in_flit[FLIT_W-1 -: 2];
   assign xd      = 32'(in_flit[XW-1:0]);
   assign yd      = 32'(in_flit[XW+YW-1:XW]);
   assign addr_ok = (xd < X_NODE_NUM) && (yd < Y_NODE_NUM);

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // X first, then Y.
   always_comb begin
      calc_port = PortL;
      if (xd > X_CUR) begin
         calc_port = PortE;
      end else if (xd < X_CUR) begin
         calc_port = PortW;
      end else if (yd > Y_CUR) begin
         calc_port = PortS;
      end else if (yd < Y_CUR) begin
         calc_port = PortN;
      end
   end

   always_comb begin
      state_d   = state_q;
      route_d   = route_q;
      emit      = 1'b0;
      emit_port = route_q;
      err_d     = 1'b0;
      if (accept) begin
         unique case (state_q)
            StIdle: begin
               if (ftype == FtHdr || ftype == FtHdrTail) begin
                  if (addr_ok) begin
                     emit      = 1'b1;
                     emit_port = calc_port;
                     if (ftype == FtHdr) begin
                        route_d = calc_port;
                        state_d = StPkt;
                     end
                  end else begin
                     err_d = 1'b1;
                     if (ftype == FtHdr) state_d = StDrop;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
            StPkt: begin
               if (ftype == FtBody || ftype == FtTail) begin
                  emit = 1'b1;
                  if (ftype == FtTail) state_d = StIdle;
               end else begin
                  err_d = 1'b1;
               end
            end
            StDrop: begin
               if (ftype == FtTail || ftype == FtHdrTail) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Output register: a dropped accept still retires the current output word.
   always_comb begin
      flit_d  = flit_q;
      valid_d = valid_q;
      port_d  = port_q;
      if (accept) begin
         valid_d = emit;
         port_d  = emit ? emit_port : PortNone;
         if (emit) flit_d = in_flit;
      end else if (out_ready) begin
         valid_d = 1'b0;
         port_d  = PortNone;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         route_q <= PortNone;
         flit_q  <= '0;
         valid_q <= 1'b0;
         port_q  <= PortNone;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         route_q <= route_d;
         flit_q  <= flit_d;
         valid_q <= valid_d;
         port_q  <= port_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      out_port_oh = 5'b00000;
      case (port_q)
         PortL:   out_port_oh = 5'b00001;
         PortE:   out_port_oh = 5'b00010;
         PortN:   out_port_oh = 5'b00100;
         PortW:   out_port_oh = 5'b01000;
         PortS:   out_port_oh = 5'b10000;
         default: out_port_oh = 5'b00000;
      endcase
   end

   assign out_flit     = flit_q;
   assign out_valid    = valid_q;
   assign out_port_num = port_q;
   assign err          = err_q;

`ifdef XY_ROUTE_ERR_CNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= 8'd0;
      end else if (err_d && err_cnt_q != 8'hFF) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_xy_route_pipe.sv
// Scoreboard bench for xy_route_pipe: packet-level reference model, random traffic and
// backpressure, plus a second instance on a 3x3 mesh for bad-address drops.
module tb_xy_route_pipe;
   localparam int XN = 4;
   localparam int YN = 4;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_flit;
   logic       in_valid, in_ready;
   logic [7:0] out_flit;
   logic       out_valid, out_ready;
   logic [2:0] out_port_num;
   logic [4:0] out_port_oh;
   logic       err;

   logic [7:0] b_in_flit;
   logic       b_in_valid, b_in_ready;
   logic [7:0] b_out_flit;
   logic       b_out_valid;
   logic [2:0] b_out_port_num;
   logic [4:0] b_out_port_oh;
   logic       b_err;
`ifdef XY_ROUTE_ERR_CNT_EN
   logic [7:0] err_cnt, b_err_cnt;
`endif

   xy_route_pipe #(
      .X_NODE_NUM(4), .Y_NODE_NUM(4), .X_CUR(1), .Y_CUR(1), .FLIT_W(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
      .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
      .out_port_num(out_port_num), .out_port_oh(out_port_oh),
`ifdef XY_ROUTE_ERR_CNT_EN
      .err(err), .err_cnt(err_cnt)
`else
      .err(err)
`endif
   );

   xy_route_pipe #(
      .X_NODE_NUM(3), .Y_NODE_NUM(3), .X_CUR(1), .Y_CUR(1), .FLIT_W(8)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .in_flit(b_in_flit), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .out_flit(b_out_flit), .out_valid(b_out_valid),
      .out_ready(1'b1), .out_port_num(b_out_port_num), .out_port_oh(b_out_port_oh),
`ifdef XY_ROUTE_ERR_CNT_EN
      .err(b_err), .err_cnt(b_err_cnt)
`else
      .err(b_err)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: packet-level view of XY routing with wormhole hold.
   typedef struct {
      logic [7:0] flit;
      logic [2:0] port;
   } exp_t;

   exp_t       q[$];
   bit         m_in_pkt, m_drop, err_exp;
   logic [2:0] m_route;
   int         m_err_total, pop_cnt, err_seen;

   function automatic logic [2:0] xy_port(input int xd, input int yd);
      if (xd > 1) return 3'd2;
      if (xd < 1) return 3'd4;
      if (yd > 1) return 3'd5;
      if (yd < 1) return 3'd3;
      return 3'd1;
   endfunction

   function automatic logic [4:0] oh_of(input logic [2:0] n);
      if (n == 3'd0 || n > 3'd5) return 5'b0;
      return 5'b1 << (n - 3'd1);
   endfunction

   task automatic flag_err();
      err_exp = 1'b1;
      m_err_total++;
   endtask

   task automatic model(input logic [7:0] f);
      exp_t e;
      bit   head, tail, good;
      head = f[7];
      tail = f[6];
      good = (int'(f[1:0]) < XN) && (int'(f[3:2]) < YN);
      if (m_drop) begin
         if (tail) m_drop = 1'b0;
      end else if (m_in_pkt) begin
         if (head) begin
            flag_err();
         end else begin
            e.flit = f;
            e.port = m_route;
            q.push_back(e);
            if (tail) m_in_pkt = 1'b0;
         end
      end else if (!head || !good) begin
         flag_err();
         if (head && !tail) m_drop = 1'b1;
      end else begin
         e.flit = f;
         e.port = xy_port(int'(f[1:0]), int'(f[3:2]));
         q.push_back(e);
         if (!tail) begin
            m_in_pkt = 1'b1;
            m_route  = e.port;
         end
      end
   endtask

   // Monitor: check outputs, then feed this cycle's accepted flit to the model.
   bit         stall_prev;
   logic [7:0] sv_flit;
   logic [2:0] sv_num;
   logic [4:0] sv_oh;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q.delete();
            m_in_pkt    = 1'b0;
            m_drop      = 1'b0;
            m_route     = 3'd0;
            err_exp     = 1'b0;
            m_err_total = 0;
            stall_prev  = 1'b0;
         end else begin
            chk("in_ready", in_ready, !out_valid || out_ready);
            chk("err", err, err_exp);
            if (err) err_seen++;
            chk("oh_vs_num", out_port_oh, oh_of(out_port_num));
            if (!out_valid) chk("idle_port", {out_port_num, out_port_oh}, 0);
            if (stall_prev) begin
               chk("stall_valid", out_valid, 1);
               chk("stall_flit", out_flit, sv_flit);
               chk("stall_num", out_port_num, sv_num);
               chk("stall_oh", out_port_oh, sv_oh);
            end
            if (out_valid && out_ready) begin
               chk("scb_nonempty", q.size() > 0, 1);
               if (q.size() > 0) begin
                  e = q.pop_front();
                  pop_cnt++;
                  chk("scb_flit", out_flit, e.flit);
                  chk("scb_port", out_port_num, e.port);
                  chk("scb_oh", out_port_oh, oh_of(e.port));
               end
            end
            stall_prev = out_valid && !out_ready;
            sv_flit    = out_flit;
            sv_num     = out_port_num;
            sv_oh      = out_port_oh;
            err_exp    = 1'b0;
            if (in_valid && in_ready) model(in_flit);
         end
      end
   end

   int         b_vcnt, b_ecnt;
   logic [2:0] b_last_port;

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (b_out_valid) begin
               b_vcnt++;
               b_last_port = b_out_port_num;
            end
            if (b_err) b_ecnt++;
         end
      end
   end

   bit bp_rand = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send(input logic [7:0] f);
      in_flit  = f;
      in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
      end
      chk("send_timeout", 1, 0);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int k);
      if (k > 0) begin
         repeat (k) @(posedge clk);
         #1;
      end
   endtask

   task automatic b_drive(input logic [7:0] f);
      b_in_flit  = f;
      b_in_valid = 1'b1;
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int         base, e0;
      logic [7:0] f;
      int         r;
      rst_n      = 1'b0;
      in_flit    = 8'h00;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      b_in_flit  = 8'h00;
      b_in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_flit", out_flit, 0);
      chk("rst_num", out_port_num, 0);
      chk("rst_oh", out_port_oh, 0);
      chk("rst_err", err, 0);
      #2 rst_n = 1'b1;
      idle(1);

      // 3x3 mesh: bad-address header drops its whole packet with one err.
      b_drive(8'h87);
      b_drive(8'h2A);
      b_drive(8'h5C);
      idle(3);
      chk("b_drop_valid", b_vcnt, 0);
      chk("b_drop_err", b_ecnt, 1);
      b_drive(8'hC4);
      idle(3);
      chk("b_idle_again", b_vcnt, 1);
      chk("b_west", b_last_port, 4);
      b_drive(8'hC3);
      b_drive(8'hC9);
      idle(3);
      chk("b_hdrtail_bad_vcnt", b_vcnt, 2);
      chk("b_hdrtail_bad_err", b_ecnt, 2);
      chk("b_south", b_last_port, 5);

      // HDR/BODY/TAIL to (3,1): back-to-back outputs, all routed East.
      base = pop_cnt;
      send(8'h87);
      send(8'h2A);
      send(8'h5C);
      @(posedge clk);
      #1;
      chk("b2b_pops", pop_cnt - base, 3);

      // Single-flit packets to (1,1), (1,0), (1,3), (0,2).
      send(8'hC5);
      send(8'hC1);
      send(8'hCD);
      send(8'hC8);
      idle(2);

      // Three-cycle stall mid-packet.
      send(8'h8D);
      send(8'h11);
      out_ready = 1'b0;
      in_flit   = 8'h77;
      in_valid  = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready_low", in_ready, 0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1 in_valid = 1'b0;
      idle(2);

      // Protocol errors: BODY in IDLE, HDR inside a packet.
      e0 = err_seen;
      send(8'h15);
      send(8'h87);
      send(8'h80);
      send(8'h40);
      idle(3);
      chk("proto_err_pulses", err_seen - e0, 2);

      // Random traffic under random backpressure.
      bp_rand = 1'b1;
      for (int i = 0; i < 400; i++) begin
         f = 8'($urandom);
         r = $urandom_range(0, 9);
         if (r < 2) f[7:6] = 2'b10;
         else if (r < 6) f[7:6] = 2'b00;
         else if (r < 8) f[7:6] = 2'b01;
         else f[7:6] = 2'b11;
         send(f);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      bp_rand = 1'b0;
      idle(1);
      out_ready = 1'b1;
      idle(4);
      chk("drain_empty", q.size(), 0);

      // Reset in the middle of a packet.
      send(8'h87);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_flit", out_flit, 0);
      chk("arst_num", out_port_num, 0);
      chk("arst_oh", out_port_oh, 0);
      chk("arst_err", err, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      idle(1);
      e0 = err_seen;
      send(8'h00);
      idle(3);
      chk("post_rst_body_err", err_seen - e0, 1);

`ifdef XY_ROUTE_ERR_CNT_EN
      chk("err_cnt_one", err_cnt, m_err_total);
      for (int i = 0; i < 300; i++) send(8'h00);
      idle(3);
      chk("err_cnt_sat", err_cnt, 255);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
